ir_scan_seq: RTL and testbench
==============================

IR_SCAN_SEQ -- requirements
Module: ir_scan_seq

Interface
REQ-001 Parameter NUM_PAIRS, default 3; number of IR emitter/receiver pairs scanned, legal range 1..4.
REQ-002 Parameter SETTLE_CYC, default 4096; clocks to wait after enabling an emitter before converting.
REQ-003 Parameter TMO_CYC, default 2048; maximum clocks to wait for cnv_cmplt.
REQ-004 Parameter RES_W, default 12; A2D result width.
REQ-005 clk  in  1  50 MHz system clock, rising edge.
REQ-006 RST_n  in  1  reset, asynchronous, active-low.
REQ-007 strt_scan  in  1  single-cycle pulse; start one scan.
REQ-008 cont  in  1  continuous mode; when high, a finished scan restarts automatically.
REQ-009 cnv_cmplt  in  1  A2D conversion-complete pulse.
REQ-010 A2D_res  in  RES_W  A2D result, valid while cnv_cmplt is high.
REQ-011 strt_cnv  out  1  single-cycle A2D start pulse.
REQ-012 chnnl  out  3  A2D channel select.
REQ-013 IR_en  out  NUM_PAIRS  one-hot emitter enables.
REQ-014 res_flat  out  2*NUM_PAIRS*RES_W  latched results; slot 2p = left of pair p, slot 2p+1 = right of pair p.
REQ-015 err  out  RES_W+NUM_PAIRS+1  signed weighted line error.
REQ-016 scan_done  out  1  single-cycle pulse when a scan completes.
REQ-017 busy  out  1  high outside IDLE.
REQ-018 tmo  out  1  sticky timeout flag; cleared by the next accepted strt_scan.

Function
REQ-019 The FSM SHALL have the states IDLE, SETTLE, CNV_L, WAIT_L, CNV_R, WAIT_R, NEXT, DONE.
REQ-020 IDLE: on strt_scan, the FSM SHALL set pair index p=0, clear tmo, clear the error accumulator, and enter SETTLE.
REQ-021 strt_scan outside IDLE SHALL be ignored.
REQ-022 SETTLE: IR_en SHALL be 1<<p; after exactly SETTLE_CYC clocks, the FSM SHALL enter CNV_L.
REQ-023 CNV_L and CNV_R SHALL each last one clock, assert strt_cnv, and drive chnnl to 2p and 2p+1 respectively.
REQ-024 chnnl SHALL hold its value from CNV_x through the matching WAIT_x state.
REQ-025 WAIT_x: on cnv_cmplt, A2D_res SHALL be latched into the corresponding res_flat slot; the FSM SHALL then enter CNV_R from WAIT_L, or NEXT from WAIT_R.
REQ-026 IR_en SHALL stay on through WAIT_R, so both readings of a pair use the same emitter.
REQ-027 NEXT: the accumulator SHALL add (right - left) * 2^p, computed as signed and sign-extended to the err width.
REQ-028 NEXT: if p < NUM_PAIRS-1, the FSM SHALL increment p and enter SETTLE; otherwise it SHALL enter DONE.
REQ-029 DONE (one clock): err SHALL take the accumulator value and scan_done SHALL pulse.
REQ-030 From DONE, the FSM SHALL go to SETTLE with p=0 and the accumulator cleared if cont is high, otherwise to IDLE.
REQ-031 err and res_flat SHALL update only as stated above and hold otherwise; they are never partially updated mid-scan.
REQ-032 If TMO_CYC clocks elapse in a WAIT_x state without cnv_cmplt, the block SHALL set tmo, drop IR_en, and return to IDLE without pulsing scan_done; err SHALL keep its previous value.
REQ-033 A timeout SHALL stop the scan even when cont is high.
REQ-034 A cnv_cmplt arriving on the same clock as the timeout expiry SHALL win (no timeout).
REQ-035 cnv_cmplt outside the WAIT states SHALL be ignored.
REQ-036 If cont is dropped mid-scan, the current scan SHALL finish, then the block SHALL go idle.
REQ-037 IR_en SHALL be all zeros in IDLE and DONE.

Reset
REQ-038 While RST_n is low, the block SHALL be in IDLE with strt_cnv=0, chnnl=0, IR_en=0, res_flat=0, err=0, scan_done=0, busy=0, tmo=0.
REQ-039 Assertion of RST_n mid-scan SHALL abort the scan immediately, with no scan_done pulse.

Structure
REQ-040 The state encoding and the default NUM_PAIRS, SETTLE_CYC and TMO_CYC values SHALL live in a shared package, ir_scan_pkg.
REQ-041 A single sub-module, ir_scan_tmr, SHALL provide a loadable down-counter shared by the settle wait and the timeout.

Verification
REQ-042 NUM_PAIRS=3, SETTLE_CYC=16; strt_scan with the model returning left=0x100 and right=0x180 for every pair -> six strt_cnv pulses on channels 0..5 in order, err = 0x80*(1+2+4) = 0x380, one scan_done pulse.
REQ-043 Left=0xFFF, right=0x000 on pair 2 only, other pairs equal -> err = -0xFFF*4 = -16380.
REQ-044 The model withholds cnv_cmplt on channel 3 -> tmo=1 after TMO_CYC clocks, IR_en=0, busy=0, no scan_done, err unchanged.
REQ-045 cont=1, scan run twice -> two scan_done pulses separated by 3*(SETTLE_CYC+conversion time)+overhead, with no IDLE visit in between; a strt_scan pulsed mid-scan has no effect.
REQ-046 RST_n asserted during WAIT_R of pair 1 -> all outputs are zero the same cycle, and a later strt_scan completes normally.

Source files
------------

// File: rtl/ir_scan_pkg.sv
// ir_scan_pkg
// Shared definitions for the IR emitter/receiver scan sequencer:
//   - default values for NUM_PAIRS, SETTLE_CYC, TMO_CYC and RES_W
//   - FSM state encoding (3-bit constants, legacy compatible)
//   - helper that sizes the shared settle/timeout down-counter
package ir_scan_pkg;

   localparam int DEF_NUM_PAIRS  = 3;
   localparam int DEF_SETTLE_CYC = 4096;
   localparam int DEF_TMO_CYC    = 2048;
   localparam int DEF_RES_W      = 12;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SETTLE = 3'd1;
   localparam logic [2:0] ST_CNV_L  = 3'd2;
   localparam logic [2:0] ST_WAIT_L = 3'd3;
   localparam logic [2:0] ST_CNV_R  = 3'd4;
   localparam logic [2:0] ST_WAIT_R = 3'd5;
   localparam logic [2:0] ST_NEXT   = 3'd6;
   localparam logic [2:0] ST_DONE   = 3'd7;

   // Counter width able to hold the larger of the two wait lengths.
   function automatic int tmr_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/ir_scan_seq_if.sv
// ir_scan_seq_if
// A2D converter handshake between the scan sequencer and the converter.
//   strt_cnv  : single-cycle conversion start (sequencer -> A2D)
//   chnnl     : channel select, held through the conversion (sequencer -> A2D)
//   cnv_cmplt : conversion-complete pulse (A2D -> sequencer)
//   A2D_res   : result, valid while cnv_cmplt is high (A2D -> sequencer)
// Modports: master = sequencer side, slave = converter side.
interface ir_scan_seq_if #(
   parameter int RES_W = ir_scan_pkg::DEF_RES_W
) ();

   logic             strt_cnv;
   logic [2:0]       chnnl;
   logic             cnv_cmplt;
   logic [RES_W-1:0] A2D_res;

   modport master (output strt_cnv, output chnnl, input cnv_cmplt, input A2D_res);
   modport slave  (input strt_cnv, input chnnl, output cnv_cmplt, output A2D_res);

endinterface

// File: rtl/ir_scan_tmr.sv
// ir_scan_tmr
// Loadable saturating down-counter shared by the emitter settle wait and
// the conversion timeout.
//   clk, RST_n : clock, asynchronous active-low reset
//   load       : load load_val this clock (takes priority over counting)
//   load_val   : value to load
//   zero       : counter has reached zero
// Loading N gives N+1 clocks until zero is first seen in the next state.
module ir_scan_tmr #(
   parameter int W = 12
) (
   input  logic         clk,
   input  logic         RST_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge RST_n) begin
      if (!RST_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/ir_scan_seq.sv
// ir_scan_seq
// Scans NUM_PAIRS IR emitter/receiver pairs: enables one emitter, waits for
// it to settle, converts the left then right receiver, and accumulates a
// signed weighted line error sum((right-left) * 2^p).
//   clk, RST_n  : clock, asynchronous active-low reset
//   strt_scan   : start one scan (ignored unless idle)
//   cont        : restart automatically after each completed scan
//   a2d         : A2D handshake (master side)
//   IR_en       : one-hot emitter enables
//   res_flat    : latched results, slot 2p = left, 2p+1 = right of pair p
//   err         : signed weighted error of the last completed scan
//   scan_done   : single-cycle completion pulse
//   busy        : high outside IDLE
//   tmo         : sticky conversion timeout flag
module ir_scan_seq import ir_scan_pkg::*; #(
   parameter int NUM_PAIRS  = DEF_NUM_PAIRS,
   parameter int SETTLE_CYC = DEF_SETTLE_CYC,
   parameter int TMO_CYC    = DEF_TMO_CYC,
   parameter int RES_W      = DEF_RES_W
) (
   input  logic                          clk,
   input  logic                          RST_n,
   input  logic                          strt_scan,
   input  logic                          cont,
   ir_scan_seq_if.master                 a2d,
   output logic [NUM_PAIRS-1:0]          IR_en,
   output logic [2*NUM_PAIRS*RES_W-1:0]  res_flat,
   output logic signed [RES_W+NUM_PAIRS:0] err,
   output logic                          scan_done,
   output logic                          busy,
   output logic                          tmo
);

   localparam int ERR_W = RES_W + NUM_PAIRS + 1;
   localparam int TMR_W = tmr_width(SETTLE_CYC, TMO_CYC);
   localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
   localparam logic [TMR_W-1:0] TMO_LD    = TMR_W'(TMO_CYC - 1);
   localparam logic [1:0]       LAST_P    = 2'(NUM_PAIRS - 1);

   logic [2:0]                 state_q, state_d;
   logic [1:0]                 p_q, p_d;
   logic [ERR_W-1:0]           acc_q, acc_d;
   logic [ERR_W-1:0]           err_q, err_d;
   logic [2*NUM_PAIRS*RES_W-1:0] res_flat_q, res_flat_d;
   logic                       tmo_q, tmo_d;

   logic                       tmr_load, tmr_zero;
   logic [TMR_W-1:0]           tmr_val;
   logic [2:0]                 chnnl_w;
   logic                       pair_active;
   logic [RES_W-1:0]           left_res, right_res;
   logic [RES_W:0]             diff;
   logic [ERR_W-1:0]           diff_ext, weighted;

   ir_scan_tmr #(.W(TMR_W)) u_tmr (
      .clk      (clk),
      .RST_n    (RST_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   // Emitter stays on from SETTLE through WAIT_R so both readings of a pair
   // see the same illumination; channel tracks the conversion in flight.
   always_comb begin
      pair_active = state_q inside {ST_SETTLE, ST_CNV_L, ST_WAIT_L, ST_CNV_R, ST_WAIT_R};
      for (int i = 0; i < NUM_PAIRS; i++) begin
         IR_en[i] = pair_active && (p_q == 2'(i));
      end
      chnnl_w = 3'd0;
      if (state_q == ST_CNV_L || state_q == ST_WAIT_L) begin
         chnnl_w = {p_q, 1'b0};
      end else if (state_q == ST_CNV_R || state_q == ST_WAIT_R) begin
         chnnl_w = {p_q, 1'b1};
      end
   end

   // Signed (right - left) of the current pair, sign-extended and weighted.
   always_comb begin
      left_res  = '0;
      right_res = '0;
      for (int i = 0; i < NUM_PAIRS; i++) begin
         if (p_q == 2'(i)) begin
            left_res  = res_flat_q[2*i*RES_W +: RES_W];
            right_res = res_flat_q[(2*i+1)*RES_W +: RES_W];
         end
      end
      diff     = {1'b0, right_res} - {1'b0, left_res};
      diff_ext = {{NUM_PAIRS{diff[RES_W]}}, diff};
      weighted = diff_ext << p_q;
   end

   // Sequencer. A conversion result is checked before the timeout so a
   // cnv_cmplt on the expiry clock still counts.
   always_comb begin
      state_d    = state_q;
      p_d        = p_q;
      acc_d      = acc_q;
      err_d      = err_q;
      res_flat_d = res_flat_q;
      tmo_d      = tmo_q;
      tmr_load   = 1'b0;
      tmr_val    = SETTLE_LD;
      case (state_q)
         ST_IDLE: begin
            if (strt_scan) begin
               p_d      = '0;
               tmo_d    = 1'b0;
               acc_d    = '0;
               tmr_load = 1'b1;
               state_d  = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (tmr_zero) begin
               state_d = ST_CNV_L;
            end
         end
         ST_CNV_L, ST_CNV_R: begin
            tmr_load = 1'b1;
            tmr_val  = TMO_LD;
            state_d  = (state_q == ST_CNV_L) ? ST_WAIT_L : ST_WAIT_R;
         end
         ST_WAIT_L, ST_WAIT_R: begin
            if (a2d.cnv_cmplt) begin
               for (int s = 0; s < 2*NUM_PAIRS; s++) begin
                  if (chnnl_w == 3'(s)) begin
                     res_flat_d[s*RES_W +: RES_W] = a2d.A2D_res;
                  end
               end
               state_d = (state_q == ST_WAIT_L) ? ST_CNV_R : ST_NEXT;
            end else if (tmr_zero) begin
               tmo_d   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_NEXT: begin
            acc_d = acc_q + weighted;
            if (p_q < LAST_P) begin
               p_d      = p_q + 2'd1;
               tmr_load = 1'b1;
               state_d  = ST_SETTLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            err_d = acc_q;
            if (cont) begin
               p_d      = '0;
               acc_d    = '0;
               tmr_load = 1'b1;
               state_d  = ST_SETTLE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge RST_n) begin
      if (!RST_n) begin
         state_q    <= ST_IDLE;
         p_q        <= '0;
         acc_q      <= '0;
         err_q      <= '0;
         res_flat_q <= '0;
         tmo_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         p_q        <= p_d;
         acc_q      <= acc_d;
         err_q      <= err_d;
         res_flat_q <= res_flat_d;
         tmo_q      <= tmo_d;
      end
   end

   assign a2d.strt_cnv = (state_q == ST_CNV_L) || (state_q == ST_CNV_R);
   assign a2d.chnnl    = chnnl_w;
   assign res_flat     = res_flat_q;
   assign err          = err_q;
   assign scan_done    = (state_q == ST_DONE);
   assign busy         = (state_q != ST_IDLE);
   assign tmo          = tmo_q;

endmodule

// File: tb/tb_ir_scan_seq.sv
// tb_ir_scan_seq
// Directed bench for ir_scan_seq with NUM_PAIRS=3, SETTLE_CYC=16, TMO_CYC=32.
// A behavioural A2D answers each strt_cnv two clocks later with a per-channel
// value, or withholds the answer for one chosen channel.
module tb_ir_scan_seq;

   localparam int NP = 3;
   localparam int SC = 16;
   localparam int TC = 32;
   localparam int RW = 12;
   localparam int EW = RW + NP + 1;

   logic                 clk;
   logic                 RST_n;
   logic                 strt_scan;
   logic                 cont;
   logic [NP-1:0]        IR_en;
   logic [2*NP*RW-1:0]   res_flat;
   logic signed [EW-1:0] err;
   logic                 scan_done;
   logic                 busy;
   logic                 tmo;

   ir_scan_seq_if #(.RES_W(RW)) a2d ();

   ir_scan_seq #(
      .NUM_PAIRS  (NP),
      .SETTLE_CYC (SC),
      .TMO_CYC    (TC),
      .RES_W      (RW)
   ) dut (
      .clk       (clk),
      .RST_n     (RST_n),
      .strt_scan (strt_scan),
      .cont      (cont),
      .a2d       (a2d),
      .IR_en     (IR_en),
      .res_flat  (res_flat),
      .err       (err),
      .scan_done (scan_done),
      .busy      (busy),
      .tmo       (tmo)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [RW-1:0] left_val  [NP];
   logic [RW-1:0] right_val [NP];
   int withhold_ch = -1;

   int done_cnt     = 0;
   int idle_cnt     = 0;
   int last_cnv_cyc = 0;
   int chan_q [$];
   int iren_q [$];
   int done_cyc_q [$];

   initial clk = 1'b0;
   always #10 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Event monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (scan_done === 1'b1) begin
         done_cnt = done_cnt + 1;
         done_cyc_q.push_back(cyc);
      end
      if (a2d.strt_cnv === 1'b1) begin
         chan_q.push_back(int'(a2d.chnnl));
         iren_q.push_back(int'(IR_en));
         last_cnv_cyc = cyc;
      end
      if (busy === 1'b0) idle_cnt = idle_cnt + 1;
   end

   // A2D model: answers two clocks after strt_cnv unless the channel is withheld.
   initial begin
      int ch;
      bit pending;
      a2d.cnv_cmplt = 1'b0;
      a2d.A2D_res   = '0;
      forever begin
         @(negedge clk);
         pending = (a2d.strt_cnv === 1'b1) && (RST_n === 1'b1);
         while (pending) begin
            pending = 1'b0;
            ch = int'(a2d.chnnl);
            if (ch != withhold_ch) begin
               repeat (2) @(negedge clk);
               if (RST_n === 1'b1) begin
                  a2d.cnv_cmplt = 1'b1;
                  a2d.A2D_res   = (ch % 2 == 0) ? left_val[ch/2] : right_val[ch/2];
               end
               @(negedge clk);
               a2d.cnv_cmplt = 1'b0;
               a2d.A2D_res   = '0;
               pending = (a2d.strt_cnv === 1'b1) && (RST_n === 1'b1);
            end
         end
      end
   end

   task automatic wait_neg();
      @(negedge clk);
      #1;
   endtask

   task automatic pulse_start();
      strt_scan = 1'b1;
      wait_neg();
      strt_scan = 1'b0;
   endtask

   task automatic set_pairs(input logic [RW-1:0] l0, input logic [RW-1:0] r0,
                            input logic [RW-1:0] l1, input logic [RW-1:0] r1,
                            input logic [RW-1:0] l2, input logic [RW-1:0] r2);
      left_val[0] = l0; right_val[0] = r0;
      left_val[1] = l1; right_val[1] = r1;
      left_val[2] = l2; right_val[2] = r2;
   endtask

   task automatic test_reset();
      RST_n = 1'b0;
      strt_scan = 1'b0;
      cont = 1'b0;
      repeat (3) wait_neg();
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
      n_tests++; if (IR_en !== '0) begin n_fail++; $display("[TB] FAIL reset_IR_en: got %b, expected 0", IR_en); end
      n_tests++; if (err !== '0) begin n_fail++; $display("[TB] FAIL reset_err: got %h, expected 0", err); end
      n_tests++; if (res_flat !== '0) begin n_fail++; $display("[TB] FAIL reset_res_flat: got %h, expected 0", res_flat); end
      n_tests++; if (a2d.strt_cnv !== 1'b0 || a2d.chnnl !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_a2d: got strt_cnv=%b chnnl=%0d, expected 0/0", a2d.strt_cnv, a2d.chnnl); end
      n_tests++; if (scan_done !== 1'b0 || tmo !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_flags: got done=%b tmo=%b, expected 0/0", scan_done, tmo); end
      RST_n = 1'b1;
      repeat (2) wait_neg();
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_after_reset: got busy=%b, expected 0", busy); end
   endtask

   task automatic run_scan_and_wait(input int start_done, output bit ok);
      pulse_start();
      for (int i = 0; i < 400 && !(done_cnt > start_done && busy === 1'b0); i++) wait_neg();
      ok = (done_cnt > start_done && busy === 1'b0);
   endtask

   task automatic test_basic_scan();
      int d0;
      bit ok;
      set_pairs(12'h100, 12'h180, 12'h100, 12'h180, 12'h100, 12'h180);
      chan_q.delete();
      iren_q.delete();
      d0 = done_cnt;
      run_scan_and_wait(d0, ok);
      n_tests++; if (!ok) begin n_fail++; $display("[TB] FAIL basic_complete: got done=%0d busy=%b, expected scan finished", done_cnt - d0, busy); end
      n_tests++; if (done_cnt - d0 != 1) begin n_fail++; $display("[TB] FAIL basic_done_count: got %0d, expected 1", done_cnt - d0); end
      n_tests++; if (chan_q.size() != 6) begin n_fail++; $display("[TB] FAIL basic_cnv_count: got %0d, expected 6", chan_q.size()); end
      for (int i = 0; i < 6 && i < chan_q.size(); i++) begin
         n_tests++; if (chan_q[i] != i) begin n_fail++; $display("[TB] FAIL basic_chnnl_%0d: got %0d, expected %0d", i, chan_q[i], i); end
         n_tests++; if (iren_q[i] != (1 << (i/2))) begin n_fail++; $display("[TB] FAIL basic_IR_en_%0d: got %0d, expected %0d", i, iren_q[i], 1 << (i/2)); end
      end
      n_tests++; if (err !== 16'h0380) begin n_fail++; $display("[TB] FAIL basic_err: got %h, expected 0380", err); end
      n_tests++; if (res_flat !== 72'h180100180100180100) begin n_fail++; $display("[TB] FAIL basic_res_flat: got %h, expected 180100180100180100", res_flat); end
      n_tests++; if (IR_en !== '0 || tmo !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_idle_outputs: got IR_en=%b tmo=%b, expected 0/0", IR_en, tmo); end
   endtask

   task automatic test_negative_err();
      int d0;
      bit ok;
      set_pairs(12'h200, 12'h200, 12'h200, 12'h200, 12'hFFF, 12'h000);
      d0 = done_cnt;
      run_scan_and_wait(d0, ok);
      n_tests++; if (!ok) begin n_fail++; $display("[TB] FAIL neg_complete: got done=%0d, expected scan finished", done_cnt - d0); end
      n_tests++; if (err !== 16'hC004) begin n_fail++; $display("[TB] FAIL neg_err: got %h, expected c004 (-16380)", err); end
      n_tests++; if (res_flat !== 72'h000FFF200200200200) begin n_fail++; $display("[TB] FAIL neg_res_flat: got %h, expected 000fff200200200200", res_flat); end
   endtask

   task automatic test_timeout();
      int d0;
      int idle_cyc;
      set_pairs(12'h111, 12'h222, 12'h111, 12'h222, 12'h111, 12'h222);
      withhold_ch = 3;
      cont = 1'b1;
      d0 = done_cnt;
      pulse_start();
      for (int i = 0; i < 400 && busy === 1'b1; i++) wait_neg();
      idle_cyc = cyc;
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL tmo_stop: got busy=%b, expected 0", busy); end
      n_tests++; if (tmo !== 1'b1) begin n_fail++; $display("[TB] FAIL tmo_flag: got %b, expected 1", tmo); end
      n_tests++; if (IR_en !== '0) begin n_fail++; $display("[TB] FAIL tmo_IR_en: got %b, expected 0", IR_en); end
      n_tests++; if (done_cnt != d0) begin n_fail++; $display("[TB] FAIL tmo_no_done: got %0d pulses, expected 0", done_cnt - d0); end
      n_tests++; if (err !== 16'hC004) begin n_fail++; $display("[TB] FAIL tmo_err_hold: got %h, expected c004", err); end
      n_tests++; if (chan_q.size() == 0 || chan_q[chan_q.size()-1] != 3) begin n_fail++; $display("[TB] FAIL tmo_last_chnnl: got %0d, expected 3", (chan_q.size() == 0) ? -1 : chan_q[chan_q.size()-1]); end
      n_tests++; if (idle_cyc - last_cnv_cyc != TC + 1) begin n_fail++; $display("[TB] FAIL tmo_length: got %0d, expected %0d", idle_cyc - last_cnv_cyc, TC + 1); end
      repeat (3) wait_neg();
      n_tests++; if (busy !== 1'b0 || tmo !== 1'b1) begin n_fail++; $display("[TB] FAIL tmo_sticky: got busy=%b tmo=%b, expected 0/1", busy, tmo); end
      withhold_ch = -1;
      cont = 1'b0;
   endtask

   task automatic test_back_to_back();
      int d0;
      int n;
      set_pairs(12'h300, 12'h100, 12'h300, 12'h100, 12'h300, 12'h100);
      cont = 1'b1;
      d0 = done_cnt;
      pulse_start();
      n_tests++; if (tmo !== 1'b0) begin n_fail++; $display("[TB] FAIL cont_tmo_clear: got %b, expected 0", tmo); end
      for (int i = 0; i < 200 && done_cnt - d0 < 1; i++) wait_neg();
      idle_cnt = 0;
      repeat (30) wait_neg();
      pulse_start();
      for (int i = 0; i < 200 && done_cnt - d0 < 2; i++) wait_neg();
      n_tests++; if (done_cnt - d0 != 2) begin n_fail++; $display("[TB] FAIL cont_two_done: got %0d, expected 2", done_cnt - d0); end
      n_tests++; if (idle_cnt != 0) begin n_fail++; $display("[TB] FAIL cont_no_idle: got %0d idle cycles, expected 0", idle_cnt); end
      n = done_cyc_q.size();
      n_tests++; if (n < 2 || done_cyc_q[n-1] - done_cyc_q[n-2] != 70) begin n_fail++; $display("[TB] FAIL cont_gap: got %0d, expected 70", (n < 2) ? -1 : done_cyc_q[n-1] - done_cyc_q[n-2]); end
      repeat (5) wait_neg();
      cont = 1'b0;
      for (int i = 0; i < 200 && busy === 1'b1; i++) wait_neg();
      n_tests++; if (done_cnt - d0 != 3) begin n_fail++; $display("[TB] FAIL cont_drop_finish: got %0d, expected 3", done_cnt - d0); end
      n_tests++; if (busy !== 1'b0 || IR_en !== '0) begin n_fail++; $display("[TB] FAIL cont_drop_idle: got busy=%b IR_en=%b, expected 0/0", busy, IR_en); end
      n_tests++; if (err !== 16'hF200) begin n_fail++; $display("[TB] FAIL cont_err: got %h, expected f200", err); end
   endtask

   task automatic test_reset_mid_scan();
      int d0;
      bit found;
      bit ok;
      set_pairs(12'h100, 12'h180, 12'h100, 12'h180, 12'h100, 12'h180);
      d0 = done_cnt;
      found = 1'b0;
      pulse_start();
      for (int i = 0; i < 200 && !found; i++) begin
         if (a2d.strt_cnv === 1'b1 && a2d.chnnl === 3'd3) found = 1'b1;
         else wait_neg();
      end
      n_tests++; if (!found) begin n_fail++; $display("[TB] FAIL rst_reach_ch3: got no conversion on channel 3, expected one"); end
      wait_neg();
      n_tests++; if (a2d.chnnl !== 3'd3 || a2d.strt_cnv !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_in_wait_r: got chnnl=%0d strt_cnv=%b busy=%b, expected 3/0/1", a2d.chnnl, a2d.strt_cnv, busy); end
      RST_n = 1'b0;
      #1;
      n_tests++; if (a2d.strt_cnv !== 1'b0 || a2d.chnnl !== 3'd0 || IR_en !== '0) begin n_fail++; $display("[TB] FAIL rst_mid_a2d: got strt_cnv=%b chnnl=%0d IR_en=%b, expected all 0", a2d.strt_cnv, a2d.chnnl, IR_en); end
      n_tests++; if (res_flat !== '0 || err !== '0) begin n_fail++; $display("[TB] FAIL rst_mid_data: got res_flat=%h err=%h, expected 0/0", res_flat, err); end
      n_tests++; if (busy !== 1'b0 || scan_done !== 1'b0 || tmo !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid_flags: got busy=%b done=%b tmo=%b, expected 0", busy, scan_done, tmo); end
      repeat (5) wait_neg();
      RST_n = 1'b1;
      repeat (2) wait_neg();
      n_tests++; if (done_cnt != d0) begin n_fail++; $display("[TB] FAIL rst_no_done: got %0d pulses, expected 0", done_cnt - d0); end
      run_scan_and_wait(d0, ok);
      n_tests++; if (!ok || done_cnt - d0 != 1) begin n_fail++; $display("[TB] FAIL rst_rescan_done: got %0d, expected 1", done_cnt - d0); end
      n_tests++; if (err !== 16'h0380) begin n_fail++; $display("[TB] FAIL rst_rescan_err: got %h, expected 0380", err); end
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      RST_n = 1'b0;
      strt_scan = 1'b0;
      cont = 1'b0;
      set_pairs('0, '0, '0, '0, '0, '0);
      test_reset();
      test_basic_scan();
      test_negative_err();
      test_timeout();
      test_back_to_back();
      test_reset_mid_scan();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
